uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single-byte UART transmit engine between NUM_REQ byte sources.
- Grants are round-robin, with optional per-source packet locking so multi-byte messages are not interleaved.
- Sequences the engine's pulse-request/ready handshake.
- Sits between on-chip debug/log producers and the uart_engine instance driving the board TX pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id (≥ clog2(NUM_REQ))
WDOG_CYCLES, 64, watchdog limit in cycles (used only with UART_ARB_WDOG_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-source byte available
req_data  in  8*NUM_REQ  byte for source i at [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet (releases lock)
req_ready  out  NUM_REQ  one-cycle accept pulse to source i
grant_id  out  ID_W  source of the byte currently in flight
busy  out  1  high in any state other than IDLE
eng_data_in  out  8  to engine data_in
eng_transfer_req  out  1  to engine transfer_req, one-cycle pulse
eng_transfer_ready  in  1  from engine transfer_ready
wdog_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=0, eng_transfer_req=0, eng_data_in=0, grant_id=0, busy=0, wdog_err=0, lock=0, rr pointer=0.
- All outputs are registered.
- Source handshake: source holds req_valid/data/last stable until it sees req_ready high. It may drop valid in the same cycle it sees ready.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE decision edge D: requires eng_transfer_ready=1 and at least one eligible valid.
  - Eligible = the locked source only, if lock=1; otherwise all sources.
  - Winner = first valid source scanning from rr pointer upward, wrapping at NUM_REQ.
  - At D: eng_data_in<=winner byte; eng_transfer_req<=1; req_ready[winner]<=1; grant_id<=winner; rr<=winner+1 mod NUM_REQ; lock<=~req_last[winner]; state->ISSUE.
- ISSUE (D+1): eng_transfer_req<=0, req_ready<=0, state->WAIT_LOW.
- WAIT_LOW: stay until eng_transfer_ready=0, then ->WAIT_HIGH.
- WAIT_HIGH: stay until eng_transfer_ready=1, then ->IDLE.
- With the in-tree engine:
  - Start bit appears at D+2.
  - eng_transfer_ready returns at D+10.
  - Earliest next decision edge is D+12.
- Lock held, locked source not valid: arbiter waits in IDLE. No other source is granted.
- No valid requests: stay IDLE; outputs hold, except the pulses, which are 0.
- Engine not ready at reset release (engine has no reset): IDLE does not issue until eng_transfer_ready=1.
- Never more than one req_ready bit high; never eng_transfer_req high for 2 consecutive cycles.
- NUM_REQ not a power of 2: rr wrap at NUM_REQ-1 -> 0.

Optional Feature:
UART_ARB_WDOG_EN
- Defined:
  - Counter resets on entry to WAIT_LOW and on WAIT_LOW->WAIT_HIGH.
  - If the counter reaches WDOG_CYCLES while in WAIT_LOW or WAIT_HIGH: state->IDLE, lock<=0, wdog_err<=1 (sticky until reset).
- Undefined: no counter; waits indefinitely; wdog_err tied 0.

Test Plan:
- Single source 0 sends 0xDA, last=1 -> req_ready[0] pulse 1 cycle after decision; eng_transfer_req 1 cycle; grant_id=0; next decision no earlier than D+12.
- Sources 0,1,2 all valid, last=1 on every byte -> grant order 0,1,2,0,...; rr wraps 3->0 with NUM_REQ=4.
- Source 1 sends 3 bytes 0x11,0x22,0x33 (last only on 0x33) while source 2 is valid -> source 2 is not granted until after 0x33 is accepted.
- Locked source 1 drops valid for 50 cycles -> no grant to 0/2/3; busy=0; resume on revalidation.
- reset_n asserted in WAIT_HIGH -> all outputs at reset values immediately. After release with engine still busy, no eng_transfer_req until eng_transfer_ready=1.
- UART_ARB_WDOG_EN defined, eng_transfer_ready held 0 by the bench -> after 64 cycles wdog_err=1 and state IDLE, lock cleared. Undefined -> busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one single-byte UART transmit engine between NUM_REQ
// byte sources. Round-robin grants with per-source packet locking, and sequencing
// of the engine's pulse-request / ready handshake.
// Optional watchdog on the engine handshake: define UART_ARB_WDOG_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [7:0]           eng_data_in,
  output logic                 eng_transfer_req,
  input  logic                 eng_transfer_ready,
  output logic                 wdog_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject parameter combinations the datapath cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < IdxW || WDOG_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWaitLow, StWaitHigh} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [IdxW-1:0]    lock_id_q, lock_id_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               xfer_q, xfer_d;
  logic               busy_q, busy_d;

  logic [IdxW-1:0]    win_idx;
  logic               win_found;
  int unsigned        cand;

`ifdef UART_ARB_WDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wdog_err_q, wdog_err_d;
  logic            wdog_hit;

  // Counter would reach the limit on this edge.
  assign wdog_hit = (cnt_q == CntW'(WDOG_CYCLES - 1));
`endif

  // Winner search: first eligible valid source from the rr pointer upward, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[IdxW'(cand)] && (!lock_q || IdxW'(cand) == lock_id_q)) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    grant_d   = grant_q;
    data_d    = data_q;
    xfer_d    = 1'b0;
    ready_d   = '0;
`ifdef UART_ARB_WDOG_EN
    wdog_err_d = wdog_err_q;
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (eng_transfer_ready && win_found) begin
          data_d           = req_data[{win_idx, 3'b000} +: 8];
          xfer_d           = 1'b1;
          ready_d[win_idx] = 1'b1;
          grant_d          = ID_W'(win_idx);
          rr_d             = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + IdxW'(1);
          lock_d           = ~req_last[win_idx];
          lock_id_d        = win_idx;
          state_d          = StIssue;
        end
      end
      StIssue:    state_d = StWaitLow;
      StWaitLow:  if (!eng_transfer_ready) state_d = StWaitHigh;
      StWaitHigh: if (eng_transfer_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

`ifdef UART_ARB_WDOG_EN
    // Counts cycles spent in the current wait state; restarts on every wait-state change.
    if (state_q == StWaitLow || state_q == StWaitHigh) begin
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (wdog_hit) begin
        state_d    = StIdle;
        lock_d     = 1'b0;
        wdog_err_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
`endif

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      ready_q   <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      xfer_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      cnt_q      <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      xfer_q    <= xfer_d;
      busy_q    <= busy_d;
`ifdef UART_ARB_WDOG_EN
      cnt_q      <= cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign req_ready        = ready_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;
  assign eng_data_in      = data_q;
  assign eng_transfer_req = xfer_q;
`ifdef UART_ARB_WDOG_EN
  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model (grant order, lock ownership, D+12 cadence).
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic [7:0]     eng_data_in;
  logic           eng_transfer_req;
  logic           eng_transfer_ready;
  logic           wdog_err;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .WDOG_CYCLES(64)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_last           (req_last),
    .req_ready          (req_ready),
    .grant_id           (grant_id),
    .busy               (busy),
    .eng_data_in        (eng_data_in),
    .eng_transfer_req   (eng_transfer_req),
    .eng_transfer_ready (eng_transfer_ready),
    .wdog_err           (wdog_err)
  );

  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  // Engine model: ready drops the edge after a request, returns 9 edges later.
  bit eng_por;
  bit eng_stuck;
  int eng_cnt;
  always @(posedge clk) begin
    if (eng_por) begin
      eng_transfer_ready <= 1'b0;
      eng_cnt            <= 0;
    end else if (eng_stuck) begin
      if (eng_transfer_req) eng_transfer_ready <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_transfer_ready <= 1'b1;
    end else if (eng_transfer_req) begin
      eng_transfer_ready <= 1'b0;
      eng_cnt            <= 9;
    end else if (!eng_transfer_ready) begin
      eng_cnt <= 3;
    end
  end

  // Source byte streams {last, byte}.
  logic [8:0] mem [N][256];
  int  wr [N];
  int  rd [N];
  bit  src_en [N];
  int  pct;

  // Reference model.
  int  rr_m, lock_src_m, last_p, n;
  bit  lock_m, model_on;
  int  glog [$];
  int  checks, fails;
  bit  s_rst, s_rdy;
  int  p0;
  int  exp2 [9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};
  int  exp3 [4] = '{1, 1, 1, 2};
  int  exp4 [4] = '{1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr_m + k) % N;
      if (v[c] && (!lock_m || c == lock_src_m)) return c;
    end
    return -1;
  endfunction

  task automatic push(input int s, input logic [7:0] b, input bit last);
    mem[s][wr[s]] = {last, b};
    wr[s]++;
  endtask

  task automatic model_reset();
    rr_m = 0; lock_m = 0; lock_src_m = 0; last_p = -1000;
  endtask

  // One cycle: snapshot what the next edge sees, check at the negedge, update sources.
  task automatic tick();
    int w;
    bit exp_p;
    logic [N-1:0] v;
    s_rst = reset_n;
    s_rdy = eng_transfer_ready;
    v     = req_valid;
    @(negedge clk);
    n++;
    if (model_on) begin
      w     = pick(v);
      exp_p = s_rst && s_rdy && (w >= 0) && (n - last_p >= 12);
      check("xfer_req", 32'(eng_transfer_req), 32'(exp_p));
      if (exp_p && eng_transfer_req === 1'b1) begin
        check("grant_id", 32'(grant_id), w);
        check("data", 32'(eng_data_in), 32'(mem[w][rd[w]][7:0]));
        check("req_ready", 32'(req_ready), 1 << w);
        glog.push_back(w);
        rr_m       = (w + 1) % N;
        lock_m     = !mem[w][rd[w]][8];
        lock_src_m = w;
        last_p     = n;
      end else begin
        check("req_ready_idle", 32'(req_ready), 0);
      end
      check("busy", 32'(busy), 32'((n - last_p) <= 10));
      check("wdog_err", 32'(wdog_err), 0);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1 && req_valid[i]) begin
        rd[i]++;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && src_en[i] && rd[i] < wr[i] && $urandom_range(99) < pct) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = mem[i][rd[i]][7:0];
        req_last[i]        = mem[i][rd[i]][8];
      end
    end
  endtask

  task automatic drain(input int budget);
    int k;
    bit pending;
    k = 0;
    pending = 1'b1;
    while (pending && k < budget) begin
      tick();
      k++;
      pending = (busy !== 1'b0);
      for (int i = 0; i < N; i++) if (rd[i] < wr[i]) pending = 1'b1;
    end
    check("drain_in_budget", 32'(k < budget), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_xfer"}, 32'(eng_transfer_req), 0);
    check({tag, "_data"}, 32'(eng_data_in), 0);
    check({tag, "_grant"}, 32'(grant_id), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_wdog"}, 32'(wdog_err), 0);
  endtask

  initial begin
    eng_por = 1'b1; eng_stuck = 1'b0;
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; src_en[i] = 1'b0; end
    pct = 100; n = 0; checks = 0; fails = 0; model_on = 1'b0;
    model_reset();

    // Reset state; engine comes up not ready.
    tick();
    eng_por = 1'b0;
    tick();
    check_reset_outputs("reset");

    // Single byte from source 0, released while the engine is still not ready.
    push(0, 8'hDA, 1'b1);
    src_en[0] = 1'b1;
    reset_n = 1'b1;
    model_on = 1'b1;
    drain(200);
    check("t1_count", glog.size(), 1);
    check("t1_grant", glog[0], 0);

    // Three sources back to back, one-byte packets: round robin at D+12 cadence.
    glog.delete();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) push(s, 8'(16 * s + r), 1'b1);
    for (int s = 0; s < 3; s++) src_en[s] = 1'b1;
    drain(400);
    check("t2_count", glog.size(), 9);
    for (int i = 0; i < 9; i++) check("t2_order", glog[i], exp2[i]);

    // Packet lock: source 2 waits for source 1's three-byte packet.
    glog.delete();
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    push(2, 8'h44, 1'b1);
    src_en[1] = 1'b1; src_en[2] = 1'b1;
    drain(300);
    check("t3_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", glog[i], exp3[i]);

    // Locked source goes quiet for 50 cycles: nobody else is granted.
    glog.delete();
    push(1, 8'h55, 1'b0);
    for (int k = 0; k < 100 && rd[1] < wr[1]; k++) tick();
    src_en[1] = 1'b0;
    push(1, 8'h66, 1'b1);
    push(0, 8'h01, 1'b1); push(2, 8'h02, 1'b1); push(3, 8'h03, 1'b1);
    src_en[0] = 1'b1; src_en[2] = 1'b1; src_en[3] = 1'b1;
    glog.delete();
    repeat (50) tick();
    check("t4_no_grant", glog.size(), 0);
    check("t4_idle", 32'(busy), 0);
    src_en[1] = 1'b1;
    drain(300);
    check("t4_count", glog.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_order", glog[i], exp4[i]);

    // Randomized traffic with random packet lengths and presentation delays.
    pct = 40;
    for (int s = 0; s < N; s++) begin
      for (int b = 0; b < 30; b++) push(s, 8'($urandom), (b == 29) || ($urandom_range(2) == 0));
      src_en[s] = 1'b1;
    end
    drain(6000);
    pct = 100;

    // Reset asserted in WAIT_HIGH; afterwards no issue until the engine is ready.
    glog.delete();
    push(3, 8'hA5, 1'b1);
    for (int k = 0; k < 60 && glog.size() == 0; k++) tick();
    check("t5_first", glog.size(), 1);
    p0 = n;
    repeat (3) tick();
    push(0, 8'h5A, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_on = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    model_on = 1'b1;
    for (int k = 0; k < 60 && glog.size() < 2; k++) tick();
    check("t5_second", glog.size(), 2);
    check("t5_grant", glog[1], 0);
    check("t5_gap", n - p0, 11);
    drain(100);

    // Engine never returns ready.
    glog.delete();
    eng_stuck = 1'b1;
    push(2, 8'h3C, 1'b0);
    for (int k = 0; k < 60 && glog.size() == 0; k++) tick();
    check("t6_issued", glog.size(), 1);
    model_on = 1'b0;
`ifdef UART_ARB_WDOG_EN
    repeat (60) tick();
    check("t6_wdog_early", 32'(wdog_err), 0);
    check("t6_busy_early", 32'(busy), 1);
    repeat (10) tick();
    check("t6_wdog", 32'(wdog_err), 1);
    check("t6_idle", 32'(busy), 0);
    eng_stuck = 1'b0;
    lock_m = 1'b0; last_p = -1000;
    push(1, 8'h77, 1'b1);
    for (int k = 0; k < 60 && rd[1] < wr[1]; k++) begin
      tick();
      if (eng_transfer_req === 1'b1) check("t6_unlocked_grant", 32'(grant_id), 1);
    end
    check("t6_src1_done", rd[1], wr[1]);
`else
    repeat (80) tick();
    check("t6_busy_held", 32'(busy), 1);
    check("t6_no_wdog", 32'(wdog_err), 0);
`endif

    // Final reset clears everything, including a sticky watchdog flag.
    reset_n = 1'b0;
    eng_stuck = 1'b0;
    tick();
    check_reset_outputs("final_rst");
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
